rom_burst_arbiter: RTL and testbench

Round-robin arbiter and burst sequencer sharing one 16x8 instruction ROM among up to four requesters. Each requester asks for a burst of 1-16 consecutive words from a start address. The block grants one requester at a time, walks the ROM address with wrap-around, and streams words back tagged with requester ID and a last-beat flag. It replaces per-client ROM copies in the fetch path.

---
 rtl/rom_pkg.sv | 18 +
 rtl/rom_array.sv | 21 ++
 rtl/rom_burst_arbiter.sv | 108 ++++++++++
 tb/tb_rom_burst_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_pkg.sv
// rtl/rom_pkg.sv - shared widths, FSM encoding and fixed ROM image for rom_burst_arbiter
package rom_pkg;

  localparam int ROM_ADDR_W = 4;
  localparam int ROM_DATA_W = 8;
  localparam int ROM_DEPTH  = 1 << ROM_ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam logic [ROM_DATA_W-1:0] ROM_IMAGE [ROM_DEPTH] = '{
    8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h12, 8'h34,
    8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hEF, 8'hF1, 8'h00
  };

endpackage

// File: rtl/rom_array.sv
// rtl/rom_array.sv - synchronous-read 16x8 ROM with registered output
module rom_array
  import rom_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [ROM_ADDR_W-1:0] addr,
  output logic [ROM_DATA_W-1:0] data
);

  // The output register doubles as the rd_data pipeline stage, so it clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= ROM_IMAGE[addr];
    end
  end

endmodule

// File: rtl/rom_burst_arbiter.sv
// rtl/rom_burst_arbiter.sv - round-robin arbiter and burst sequencer over a shared 16x8 ROM
module rom_burst_arbiter
  import rom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = ROM_ADDR_W,
  parameter int DATA_W  = ROM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_len,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rd_valid,
  output logic [DATA_W-1:0]         rd_data,
  output logic [1:0]                rd_id,
  output logic                      rd_last,
  output logic                      busy
);

  state_t            state, state_nxt;
  logic [1:0]        last_winner, winner, cand, cur_id;
  logic              found, grant_now, issue;
  logic [ADDR_W-1:0] cur_addr, remaining;
  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [ADDR_W-1:0] len_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign len_arr[g]  = req_len[g*ADDR_W +: ADDR_W];
  end

  // Search begins one past the previous winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = last_winner;
    cand   = last_winner;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = 2'((int'(last_winner) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_now = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        issue = 1'b1;
        if (remaining == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_winner <= 2'(NUM_REQ - 1);
      cur_addr    <= '0;
      remaining   <= '0;
      cur_id      <= '0;
      gnt         <= '0;
      rd_valid    <= 1'b0;
      rd_id       <= '0;
      rd_last     <= 1'b0;
    end else begin
      state    <= state_nxt;
      gnt      <= grant_now ? (NUM_REQ'(1) << winner) : '0;
      rd_valid <= issue;
      rd_id    <= cur_id;
      rd_last  <= issue && (remaining == '0);
      if (grant_now) begin
        last_winner <= winner;
        cur_addr    <= addr_arr[winner];
        remaining   <= len_arr[winner];
        cur_id      <= winner;
      end else if (issue) begin
        cur_addr  <= cur_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  rom_array u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (issue),
    .addr (cur_addr),
    .data (rd_data)
  );

  assign busy = (state != IDLE) || rd_valid;

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// tb/tb_rom_burst_arbiter.sv - self-checking bench for rom_burst_arbiter against a cycle-indexed burst model
module tb_rom_burst_arbiter;

  localparam int MAXC = 4096;
  localparam logic [7:0] ROM_M [16] = '{
    8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h12, 8'h34,
    8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hEF, 8'hF1, 8'h00
  };

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [3:0]  gnt;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [1:0]  rd_id;
  logic        rd_last;
  logic        busy;

  rom_burst_arbiter #(.NUM_REQ(4), .ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .gnt      (gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_id    (rd_id),
    .rd_last  (rd_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit chk     = 1'b0;

  // Expected outputs indexed by clock edge count since reset release.
  logic       ev  [MAXC];
  logic [7:0] ed  [MAXC];
  logic [1:0] eid [MAXC];
  logic       el  [MAXC];
  logic [3:0] eg  [MAXC];
  logic       eb  [MAXC];

  int last_w, next_free, drop_id, drop_at;
  int raddr [4];
  int rlen  [4];
  bit rand_mode = 1'b0;
  bit fair_mode = 1'b0;

  logic [7:0] obs_data [$];
  int         obs_id   [$];
  int         obs_last [$];
  int         obs_cyc  [$];
  int         obs_gnt  [$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_obs(input string nm, input int i, input logic [7:0] d, input int id, input int last);
    vectors++;
    if (i >= obs_data.size()) begin
      errors++;
      $display("FAIL %s beat %0d missing: got %0d beats", nm, i, obs_data.size());
    end else if (obs_data[i] !== d || obs_id[i] != id || obs_last[i] != last) begin
      errors++;
      $display("FAIL %s beat %0d got data=%h id=%0d last=%0d want data=%h id=%0d last=%0d",
               nm, i, obs_data[i], obs_id[i], obs_last[i], d, id, last);
    end
  endtask

  function automatic int gnt_at(input int i);
    return (i < obs_gnt.size()) ? obs_gnt[i] : -1;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < obs_cyc.size()) ? obs_cyc[i] : -1;
  endfunction

  always @(negedge clk) begin
    if (chk && !rst) begin
      cmp("gnt", 32'(gnt), 32'(eg[cyc]));
      cmp("rd_valid", 32'(rd_valid), 32'(ev[cyc]));
      cmp("busy", 32'(busy), 32'(eb[cyc]));
      if (ev[cyc]) begin
        cmp("rd_data", 32'(rd_data), 32'(ed[cyc]));
        cmp("rd_id", 32'(rd_id), 32'(eid[cyc]));
        cmp("rd_last", 32'(rd_last), 32'(el[cyc]));
      end
      if (rd_valid) begin
        obs_data.push_back(rd_data);
        obs_id.push_back(int'(rd_id));
        obs_last.push_back(int'(rd_last));
        obs_cyc.push_back(cyc);
      end
      for (int i = 0; i < 4; i++) if (gnt[i]) obs_gnt.push_back(i);
    end
  end

  task automatic clear_model();
    for (int i = 0; i < MAXC; i++) begin
      ev[i] = 1'b0; ed[i] = '0; eid[i] = '0; el[i] = 1'b0; eg[i] = '0; eb[i] = 1'b0;
    end
    last_w = 3; next_free = 0; drop_id = -1; drop_at = -1; cyc = 0;
    obs_data.delete(); obs_id.delete(); obs_last.delete(); obs_cyc.delete(); obs_gnt.delete();
  endtask

  task automatic do_reset();
    chk = 1'b0; rst = 1'b1; req = '0; req_addr = '0; req_len = '0;
    rand_mode = 1'b0; fair_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_gnt", 32'(gnt), 32'h0);
    cmp("rst_rd_valid", 32'(rd_valid), 32'h0);
    cmp("rst_rd_data", 32'(rd_data), 32'h0);
    cmp("rst_rd_id", 32'(rd_id), 32'h0);
    cmp("rst_rd_last", 32'(rd_last), 32'h0);
    cmp("rst_busy", 32'(busy), 32'h0);
    clear_model();
    rst = 1'b0; chk = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input int a, input int l);
    req[i] = 1'b1;
    raddr[i] = a; rlen[i] = l;
    req_addr[i*4 +: 4] = 4'(a);
    req_len[i*4 +: 4]  = 4'(l);
  endtask

  // Drive one cycle from a negedge: update requesters, predict the next edge, advance.
  task automatic cycle_step();
    int t, w, a, l;
    if (fair_mode) begin
      if (!req[1]) set_req(1, int'($urandom_range(0, 15)), 0);
      if (!req[3]) set_req(3, int'($urandom_range(0, 15)), 0);
    end
    if (drop_id >= 0 && drop_at == cyc) begin
      req[drop_id] = 1'b0;
      drop_id = -1;
    end
    if (rand_mode) begin
      for (int i = 0; i < 4; i++)
        if (!req[i] && $urandom_range(0, 4) == 0)
          set_req(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    t = cyc + 1;
    if (t >= next_free && req != '0) begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (last_w + k) % 4;
        if (w < 0 && req[c]) w = c;
      end
      a = raddr[w]; l = rlen[w];
      eg[t] = 4'(1 << w);
      for (int b = 0; b <= l; b++) begin
        ev[t+1+b]  = 1'b1;
        ed[t+1+b]  = ROM_M[4'(a + b)];
        eid[t+1+b] = 2'(w);
        el[t+1+b]  = (b == l);
      end
      for (int b = t; b <= t + l + 1; b++) eb[b] = 1'b1;
      next_free = t + l + 2;
      last_w = w; drop_id = w; drop_at = t;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Single burst from address 0.
    do_reset();
    set_req(0, 0, 3);
    repeat (8) cycle_step();
    cmp("t1_gnt_count", 32'(obs_gnt.size()), 32'd1);
    cmp("t1_gnt_id", 32'(gnt_at(0)), 32'd0);
    check_obs("t1", 0, 8'hA1, 0, 0);
    check_obs("t1", 1, 8'hB2, 0, 0);
    check_obs("t1", 2, 8'hC3, 0, 0);
    check_obs("t1", 3, 8'hD4, 0, 1);
    cmp("t1_first_cyc", 32'(cyc_at(0)), 32'd2);
    cmp("t1_last_cyc", 32'(cyc_at(3)), 32'd5);

    // Address wrap 15 -> 0.
    do_reset();
    set_req(2, 14, 2);
    repeat (7) cycle_step();
    check_obs("t2", 0, 8'hF1, 2, 0);
    check_obs("t2", 1, 8'h00, 2, 0);
    check_obs("t2", 2, 8'hA1, 2, 1);
    cmp("t2_beats", 32'(obs_data.size()), 32'd3);

    // All four at once, single beats: rotation from 0 with one bubble between beats.
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, i, 0);
    repeat (12) cycle_step();
    for (int i = 0; i < 4; i++) cmp("t3_gnt_order", 32'(gnt_at(i)), 32'(i));
    check_obs("t3", 0, 8'hA1, 0, 1);
    check_obs("t3", 1, 8'hB2, 1, 1);
    check_obs("t3", 2, 8'hC3, 2, 1);
    check_obs("t3", 3, 8'hD4, 3, 1);
    for (int i = 0; i < 3; i++) cmp("t3_bubble", 32'(cyc_at(i+1) - cyc_at(i)), 32'd2);

    // Fairness between requesters 1 and 3.
    do_reset();
    fair_mode = 1'b1;
    set_req(1, 3, 0);
    set_req(3, 7, 0);
    repeat (20) cycle_step();
    fair_mode = 1'b0;
    for (int i = 0; i < 6; i++) cmp("t4_alternate", 32'(gnt_at(i)), (i % 2 == 0) ? 32'd1 : 32'd3);
    req = '0;
    repeat (4) cycle_step();

    // Reset after the third beat of a 16-beat burst.
    do_reset();
    set_req(0, 0, 15);
    for (int n = 0; n < 10 && obs_data.size() < 3; n++) begin
      cycle_step();
      #1;
    end
    cmp("t5_beats_before_rst", 32'(obs_data.size()), 32'd3);
    chk = 1'b0;
    rst = 1'b1;
    #1;
    cmp("t5_gnt", 32'(gnt), 32'h0);
    cmp("t5_rd_valid", 32'(rd_valid), 32'h0);
    cmp("t5_rd_data", 32'(rd_data), 32'h0);
    cmp("t5_rd_id", 32'(rd_id), 32'h0);
    cmp("t5_rd_last", 32'(rd_last), 32'h0);
    cmp("t5_busy", 32'(busy), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      cmp("t5_no_valid_in_rst", 32'(rd_valid), 32'h0);
    end
    do_reset();
    set_req(0, 0, 0);
    repeat (5) cycle_step();
    cmp("t5_regrant", 32'(gnt_at(0)), 32'd0);
    check_obs("t5_after", 0, 8'hA1, 0, 1);
    cmp("t5_after_beats", 32'(obs_data.size()), 32'd1);

    // Maximum burst with wrap.
    do_reset();
    set_req(1, 5, 15);
    repeat (22) cycle_step();
    cmp("t6_beats", 32'(obs_data.size()), 32'd16);
    check_obs("t6", 0, 8'hF6, 1, 0);
    check_obs("t6", 10, 8'h00, 1, 0);
    check_obs("t6", 11, 8'hA1, 1, 0);
    check_obs("t6", 15, 8'hE5, 1, 1);
    cmp("t6_last_cyc", 32'(cyc_at(15)), 32'd17);

    // Randomized traffic, then drain outstanding requests.
    do_reset();
    rand_mode = 1'b1;
    repeat (1500) cycle_step();
    rand_mode = 1'b0;
    repeat (120) cycle_step();
    cmp("rand_drained", 32'(req), 32'h0);

    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
